// File: rtl/dbus_ctrl.sv
// Data-bus controller: runs one core load/store as a single external bus cycle,
// with lane placement, load extension, alignment checks and an ack timeout.
module dbus_ctrl #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        core_req,
    input  logic        core_we,
    input  logic [1:0]  core_size,
    input  logic        core_unsigned,
    input  logic [31:0] core_addr,
    input  logic [31:0] core_wdata,
    output logic        core_busy,
    output logic        core_ack,
    output logic        core_err,
    output logic [31:0] core_rdata,
    output logic [31:0] DAD,
    output logic        MREQ,
    output logic        WRITE,
    output logic [1:0]  SIZE,
    output logic [31:0] ddt_o,
    output logic        ddt_oe,
    input  logic [31:0] ddt_i,
    input  logic        ACKD_n
);

    typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              mreq_q, mreq_d;
    logic              write_q, write_d;
    logic              uns_q, uns_d;
    logic              ack_q, ack_d;
    logic              err_q, err_d;
    logic [1:0]        size_q, size_d;
    logic [31:0]       dad_q, dad_d;
    logic [31:0]       ddt_q, ddt_d;
    logic [31:0]       rdata_q, rdata_d;

    logic              misaligned;
    logic [31:0]       lanes;
    logic [7:0]        rd_byte;
    logic [15:0]       rd_half;
    logic [31:0]       rd_ext;

    always_comb begin
        case (core_size)
            2'b00:   misaligned = 1'b0;
            2'b01:   misaligned = core_addr[0];
            2'b10:   misaligned = |core_addr[1:0];
            default: misaligned = 1'b1;
        endcase
    end

    // Narrow stores are replicated across every lane so the slave can pick any.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            always_comb begin
                case (core_size)
                    2'b00:   lanes[gi*8 +: 8] = core_wdata[7:0];
                    2'b01:   lanes[gi*8 +: 8] = core_wdata[(gi%2)*8 +: 8];
                    default: lanes[gi*8 +: 8] = core_wdata[gi*8 +: 8];
                endcase
            end
        end
    endgenerate

    always_comb begin
        case (dad_q[1:0])
            2'b00:   rd_byte = ddt_i[7:0];
            2'b01:   rd_byte = ddt_i[15:8];
            2'b10:   rd_byte = ddt_i[23:16];
            default: rd_byte = ddt_i[31:24];
        endcase
        rd_half = dad_q[1] ? ddt_i[31:16] : ddt_i[15:0];
        case (size_q)
            2'b00:   rd_ext = uns_q ? {24'b0, rd_byte} : {{24{rd_byte[7]}}, rd_byte};
            2'b01:   rd_ext = uns_q ? {16'b0, rd_half} : {{16{rd_half[15]}}, rd_half};
            default: rd_ext = ddt_i;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mreq_d  = mreq_q;
        write_d = write_q;
        uns_d   = uns_q;
        size_d  = size_q;
        dad_d   = dad_q;
        ddt_d   = ddt_q;
        rdata_d = rdata_q;
        ack_d   = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (core_req) begin
                    if (misaligned) begin
                        err_d = 1'b1;
                    end else begin
                        dad_d   = core_addr;
                        size_d  = core_size;
                        write_d = core_we;
                        uns_d   = core_unsigned;
                        ddt_d   = lanes;
                        mreq_d  = 1'b1;
                        cnt_d   = '0;
                        state_d = BUS;
                    end
                end
            end
            BUS: begin
                // An ack arriving on the timeout edge still completes normally.
                if (!ACKD_n) begin
                    mreq_d  = 1'b0;
                    ack_d   = 1'b1;
                    rdata_d = write_q ? 32'h0 : rd_ext;
                    state_d = RESP;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    mreq_d  = 1'b0;
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            mreq_q  <= 1'b0;
            write_q <= 1'b0;
            uns_q   <= 1'b0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            size_q  <= 2'b00;
            dad_q   <= 32'h0;
            ddt_q   <= 32'h0;
            rdata_q <= 32'h0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mreq_q  <= mreq_d;
            write_q <= write_d;
            uns_q   <= uns_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            size_q  <= size_d;
            dad_q   <= dad_d;
            ddt_q   <= ddt_d;
            rdata_q <= rdata_d;
        end
    end

    assign core_busy  = (state_q != IDLE);
    assign core_ack   = ack_q;
    assign core_err   = err_q;
    assign core_rdata = rdata_q;
    assign DAD        = dad_q;
    assign MREQ       = mreq_q;
    assign WRITE      = write_q;
    assign SIZE       = size_q;
    assign ddt_o      = ddt_q;
    assign ddt_oe     = mreq_q & write_q;

endmodule

// File: tb/tb_dbus_ctrl.sv
// Scoreboard bench for dbus_ctrl: expected responses are queued at request
// time and matched against core_ack/core_err pulses as they appear.
module tb_dbus_ctrl;

    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        core_req = 1'b0;
    logic        core_we = 1'b0;
    logic [1:0]  core_size = 2'b00;
    logic        core_unsigned = 1'b0;
    logic [31:0] core_addr = 32'h0;
    logic [31:0] core_wdata = 32'h0;
    logic        core_busy, core_ack, core_err;
    logic [31:0] core_rdata, DAD, ddt_o;
    logic        MREQ, WRITE, ddt_oe;
    logic [1:0]  SIZE;
    logic [31:0] ddt_i = 32'h0;
    logic        ACKD_n = 1'b1;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        bit          is_err;
        logic [31:0] rdata;
        string       tag;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;

    dbus_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(5)) dut (
        .clk(clk), .rst(rst),
        .core_req(core_req), .core_we(core_we), .core_size(core_size),
        .core_unsigned(core_unsigned), .core_addr(core_addr), .core_wdata(core_wdata),
        .core_busy(core_busy), .core_ack(core_ack), .core_err(core_err),
        .core_rdata(core_rdata), .DAD(DAD), .MREQ(MREQ), .WRITE(WRITE),
        .SIZE(SIZE), .ddt_o(ddt_o), .ddt_oe(ddt_oe), .ddt_i(ddt_i), .ACKD_n(ACKD_n)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Response monitor: every ack/err pulse must match the head of the scoreboard.
    always @(negedge clk) begin
        if (!rst && (core_ack || core_err)) begin
            if (sb_q.size() == 0) begin
                check("unexpected_resp", {30'b0, core_ack, core_err}, 32'h0);
            end else begin
                mon_e = sb_q.pop_front();
                check({mon_e.tag, "_err"}, {31'b0, core_err}, {31'b0, mon_e.is_err});
                check({mon_e.tag, "_ack"}, {31'b0, core_ack}, {31'b0, !mon_e.is_err});
                if (!mon_e.is_err) begin
                    check({mon_e.tag, "_rdata"}, core_rdata, mon_e.rdata);
                    check({mon_e.tag, "_busy_in_resp"}, {31'b0, core_busy}, 32'h1);
                end
                $display("txn %s ack=%0b err=%0b rdata=0x%08h", mon_e.tag, core_ack, core_err, core_rdata);
            end
        end
    end

    task automatic push_exp(input bit is_err, input logic [31:0] rdata, input string tag);
        exp_t e;
        e.is_err = is_err;
        e.rdata  = rdata;
        e.tag    = tag;
        sb_q.push_back(e);
    endtask

    task automatic drive_req(input bit we, input logic [1:0] size, input bit uns,
                             input logic [31:0] addr, input logic [31:0] wdata);
        @(negedge clk);
        core_req = 1'b1; core_we = we; core_size = size; core_unsigned = uns;
        core_addr = addr; core_wdata = wdata;
        @(negedge clk);
        core_req = 1'b0;
    endtask

    // One bus transfer; ack_cycle = MREQ-high cycle in which ACKD_n is low (0 = never).
    task automatic run_txn(input string tag, input bit we, input logic [1:0] size, input bit uns,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [31:0] rdv, input int ack_cycle,
                           input logic [31:0] exp_rdata, input logic [31:0] exp_ddt,
                           input bit poke_req);
        int width;
        if (ack_cycle == 0) push_exp(1'b1, 32'h0, tag);
        else                push_exp(1'b0, exp_rdata, tag);
        drive_req(we, size, uns, addr, wdata);
        width = 0;
        while (MREQ && width < 40) begin
            width++;
            check({tag, "_dad"}, DAD, addr);
            check({tag, "_write"}, {31'b0, WRITE}, {31'b0, we});
            check({tag, "_size"}, {30'b0, SIZE}, {30'b0, size});
            check({tag, "_oe"}, {31'b0, ddt_oe}, {31'b0, we});
            check({tag, "_busy"}, {31'b0, core_busy}, 32'h1);
            if (we) check({tag, "_ddt_o"}, ddt_o, exp_ddt);
            if (poke_req && width == 2) begin
                core_req = 1'b1; core_addr = 32'h400; core_size = 2'b10; core_we = 1'b0;
            end
            if (width == ack_cycle) begin
                ACKD_n = 1'b0; ddt_i = rdv;
            end
            @(negedge clk);
            core_req = 1'b0;
            ACKD_n = 1'b1;
            ddt_i = $urandom;
        end
        check({tag, "_mreq_width"}, width, (ack_cycle == 0) ? TIMEOUT : ack_cycle);
        if (ack_cycle == 0) check({tag, "_busy_after_to"}, {31'b0, core_busy}, 32'h0);
        @(negedge clk);
        check({tag, "_idle"}, {31'b0, core_busy}, 32'h0);
        check({tag, "_mreq_low"}, {31'b0, MREQ}, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clk);
        check("rst_mreq", {31'b0, MREQ}, 32'h0);
        check("rst_write", {31'b0, WRITE}, 32'h0);
        check("rst_oe", {31'b0, ddt_oe}, 32'h0);
        check("rst_ack", {31'b0, core_ack}, 32'h0);
        check("rst_err", {31'b0, core_err}, 32'h0);
        check("rst_busy", {31'b0, core_busy}, 32'h0);
        check("rst_dad", DAD, 32'h0);
        check("rst_size", {30'b0, SIZE}, 32'h0);
        check("rst_ddt_o", ddt_o, 32'h0);
        check("rst_rdata", core_rdata, 32'h0);
        rst = 1'b0;

        run_txn("ld_word",   0, 2'b10, 0, 32'h100, 32'h0, 32'hDEADBEEF, 4, 32'hDEADBEEF, 32'h0, 0);
        run_txn("ld_byte_s", 0, 2'b00, 0, 32'h103, 32'h0, 32'h80123456, 2, 32'hFFFFFF80, 32'h0, 0);
        run_txn("ld_byte_u", 0, 2'b00, 1, 32'h103, 32'h0, 32'h80123456, 1, 32'h00000080, 32'h0, 0);
        run_txn("ld_byte1",  0, 2'b00, 0, 32'h101, 32'h0, 32'h00007F00, 3, 32'h0000007F, 32'h0, 0);
        run_txn("ld_half_hi",0, 2'b01, 0, 32'h102, 32'h0, 32'h80017FFF, 2, 32'hFFFF8001, 32'h0, 0);
        run_txn("ld_half_u", 0, 2'b01, 1, 32'h100, 32'h0, 32'h1234F00D, 2, 32'h0000F00D, 32'h0, 1);
        run_txn("st_half",   1, 2'b01, 0, 32'h202, 32'h0000ABCD, 32'h55AA55AA, 3, 32'h0, 32'hABCDABCD, 0);
        run_txn("st_byte",   1, 2'b00, 0, 32'h203, 32'h123456A5, 32'hFFFFFFFF, 1, 32'h0, 32'hA5A5A5A5, 0);
        run_txn("st_word",   1, 2'b10, 0, 32'h204, 32'h12345678, 32'h0, 2, 32'h0, 32'h12345678, 0);
        run_txn("ack_at_to", 0, 2'b10, 0, 32'h300, 32'h0, 32'hCAFEF00D, TIMEOUT, 32'hCAFEF00D, 32'h0, 0);
        run_txn("timeout",   0, 2'b10, 0, 32'h304, 32'h0, 32'h0, 0, 32'h0, 32'h0, 0);

        // Misaligned / illegal requests: err next cycle, no bus cycle.
        push_exp(1'b1, 32'h0, "mis_word");
        drive_req(0, 2'b10, 0, 32'h101, 32'h0);
        check("mis_word_mreq", {31'b0, MREQ}, 32'h0);
        check("mis_word_busy", {31'b0, core_busy}, 32'h0);
        push_exp(1'b1, 32'h0, "mis_half");
        drive_req(1, 2'b01, 0, 32'h201, 32'h0);
        check("mis_half_mreq", {31'b0, MREQ}, 32'h0);
        push_exp(1'b1, 32'h0, "bad_size");
        drive_req(0, 2'b11, 0, 32'h200, 32'h0);
        check("bad_size_mreq", {31'b0, MREQ}, 32'h0);

        // Stray ack while idle must produce nothing.
        ACKD_n = 1'b0;
        repeat (3) @(negedge clk);
        ACKD_n = 1'b1;
        check("idle_ack_mreq", {31'b0, MREQ}, 32'h0);

        // Reset mid-transfer drops MREQ without a clock edge; no response follows.
        drive_req(0, 2'b10, 0, 32'h500, 32'h0);
        check("pre_rst_mreq", {31'b0, MREQ}, 32'h1);
        #2 rst = 1'b1;
        #1 check("async_rst_mreq", {31'b0, MREQ}, 32'h0);
        check("async_rst_busy", {31'b0, core_busy}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        ACKD_n = 1'b0;
        repeat (3) @(negedge clk);
        ACKD_n = 1'b1;
        repeat (2) @(negedge clk);

        check("sb_empty", sb_q.size(), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
